// File: rtl/ball_engine_pkg.sv
// Shared types and constants for the ball sprite engine: screen geometry, colours,
// engine states and the span-overlap helper used for the paddle hit test.
package ball_engine_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [2:0] COL_WHITE = 3'b111;
    localparam logic [2:0] COL_BLACK = 3'b000;

    typedef logic [2:0] colour_t;
    typedef logic [7:0] xpos_t;
    typedef logic [6:0] ypos_t;
    typedef logic [2:0] scan_idx_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAW,
        ST_WAIT,
        ST_ERASE,
        ST_MOVE
    } state_t;

    // Inclusive spans [a_lo, a_lo+a_len-1] and [b_lo, b_lo+b_len-1]; 9-bit so the ends never wrap.
    function automatic logic spans_overlap(input logic [8:0] a_lo, input logic [8:0] a_len,
                                           input logic [8:0] b_lo, input logic [8:0] b_len);
        return (a_lo <= b_lo + b_len - 9'd1) && (b_lo <= a_lo + a_len - 9'd1);
    endfunction

endpackage

// File: rtl/ball_engine_if.sv
// Plot requester port between the ball engine (master) and the shared VGA plot arbiter (slave).
interface ball_engine_if;
    import ball_engine_pkg::*;

    logic    plot_req;
    logic    plot_gnt;
    logic    plot;
    xpos_t   x_out;
    ypos_t   y_out;
    colour_t colour_out;

    modport master (
        output plot_req, plot, x_out, y_out, colour_out,
        input  plot_gnt
    );

    modport slave (
        input  plot_req, plot, x_out, y_out, colour_out,
        output plot_gnt
    );

endinterface

// File: rtl/ball_engine_sprite_scan.sv
// Row-major W x H offset counter shared by the erase and draw passes; moves only on step.
module ball_engine_sprite_scan
    import ball_engine_pkg::*;
#(
    parameter int W = 4,
    parameter int H = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      clear,
    input  logic      step,
    output scan_idx_t col,
    output scan_idx_t row,
    output logic      last
);

    scan_idx_t col_q, col_d;
    scan_idx_t row_q, row_d;
    logic      col_end;
    logic      row_end;

    assign col_end = (col_q == scan_idx_t'(W - 1));
    assign row_end = (row_q == scan_idx_t'(H - 1));

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clear) begin
            col_d = '0;
            row_d = '0;
        end else if (step) begin
            if (col_end) begin
                col_d = '0;
                row_d = row_end ? '0 : row_q + scan_idx_t'(1);
            end else begin
                col_d = col_q + scan_idx_t'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col  = col_q;
    assign row  = row_q;
    assign last = col_end && row_end;

endmodule

// File: rtl/ball_engine.sv
// Ball sprite engine: per-frame ERASE -> MOVE -> DRAW with wall/paddle bounces, driving one
// requester of the shared VGA plot arbiter. Pixels are emitted only on granted cycles.
module ball_engine
    import ball_engine_pkg::*;
#(
    parameter int      BALL_W      = 4,
    parameter int      BALL_H      = 4,
    parameter int      X_MIN       = 0,
    parameter int      X_MAX       = SCREEN_W - 1,
    parameter int      Y_MIN       = 0,
    parameter int      Y_MAX       = SCREEN_H - 1,
    parameter int      DX          = 1,
    parameter int      DY          = 1,
    parameter int      X_INIT      = 50,
    parameter int      Y_INIT      = 60,
    parameter int      FRAME_TICKS = 833333,
    parameter int      PADDLE_W    = 16,
    parameter colour_t BALL_COL    = COL_WHITE,
    parameter colour_t BG_COL      = COL_BLACK
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 pause,
    input  logic [7:0]           paddle_x,
    ball_engine_if.master        plot_if,
    output logic                 frame_done,
    output logic                 hit,
    output logic                 miss,
    output logic                 busy
);

    localparam int XR      = X_MAX - BALL_W + 1;
    localparam int YB      = Y_MAX - BALL_H + 1;
    localparam int TIMER_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

    state_t               state_q, state_d;
    xpos_t                ball_x_q, ball_x_d;
    ypos_t                ball_y_q, ball_y_d;
    logic                 dir_x_neg_q, dir_x_neg_d;
    logic                 dir_y_neg_q, dir_y_neg_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 plot_req_q, plot_req_d;
    logic                 busy_q, busy_d;
    colour_t              colour_q, colour_d;

    scan_idx_t            scan_col;
    scan_idx_t            scan_row;
    logic                 scan_last;
    logic                 scan_step;
    logic                 scan_clear;
    logic                 at_bottom;
    logic                 paddle_overlap;

    // Counter is held at zero outside the scan states, so it always enters ERASE/DRAW cleared.
    assign scan_step  = plot_req_q & plot_if.plot_gnt;
    assign scan_clear = ~plot_req_q;

    ball_engine_sprite_scan #(
        .W (BALL_W),
        .H (BALL_H)
    ) u_scan (
        .clk   (clk),
        .reset (reset),
        .clear (scan_clear),
        .step  (scan_step),
        .col   (scan_col),
        .row   (scan_row),
        .last  (scan_last)
    );

    assign at_bottom      = !dir_y_neg_q && ({2'b00, ball_y_q} + 9'(DY) >= 9'(YB));
    assign paddle_overlap = spans_overlap({1'b0, ball_x_q}, 9'(BALL_W),
                                          {1'b0, paddle_x}, 9'(PADDLE_W));

    always_comb begin
        state_d     = state_q;
        ball_x_d    = ball_x_q;
        ball_y_d    = ball_y_q;
        dir_x_neg_d = dir_x_neg_q;
        dir_y_neg_d = dir_y_neg_q;
        timer_d     = timer_q;

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_DRAW;
            end
            ST_DRAW: begin
                if (scan_step && scan_last) begin
                    state_d = ST_WAIT;
                    timer_d = '0;
                end
            end
            ST_WAIT: begin
                if (!pause) begin
                    if (timer_q == TIMER_W'(FRAME_TICKS - 1)) state_d = ST_ERASE;
                    else                                      timer_d = timer_q + TIMER_W'(1);
                end
            end
            ST_ERASE: begin
                if (scan_step && scan_last) state_d = ST_MOVE;
            end
            ST_MOVE: begin
                state_d = ST_DRAW;
                if (!dir_x_neg_q) begin
                    if ({1'b0, ball_x_q} + 9'(DX) >= 9'(XR)) begin
                        ball_x_d    = xpos_t'(XR);
                        dir_x_neg_d = 1'b1;
                    end else begin
                        ball_x_d    = ball_x_q + xpos_t'(DX);
                    end
                end else if ({1'b0, ball_x_q} < 9'(X_MIN + DX)) begin
                    ball_x_d    = xpos_t'(X_MIN);
                    dir_x_neg_d = 1'b0;
                end else begin
                    ball_x_d    = ball_x_q - xpos_t'(DX);
                end

                // Both axes resolve in this one cycle; a miss overrides the x result with a respawn.
                if (at_bottom) begin
                    if (paddle_overlap) begin
                        ball_y_d    = ypos_t'(YB);
                        dir_y_neg_d = 1'b1;
                    end else begin
                        ball_x_d    = xpos_t'(X_INIT);
                        ball_y_d    = ypos_t'(Y_INIT);
                        dir_x_neg_d = 1'b0;
                        dir_y_neg_d = 1'b0;
                    end
                end else if (!dir_y_neg_q) begin
                    ball_y_d    = ball_y_q + ypos_t'(DY);
                end else if ({2'b00, ball_y_q} < 9'(Y_MIN + DY)) begin
                    ball_y_d    = ypos_t'(Y_MIN);
                    dir_y_neg_d = 1'b0;
                end else begin
                    ball_y_d    = ball_y_q - ypos_t'(DY);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        plot_req_d = (state_d == ST_ERASE) || (state_d == ST_DRAW);
        busy_d     = !((state_d == ST_IDLE) || (state_d == ST_WAIT));
        colour_d   = (state_d == ST_DRAW) ? BALL_COL : BG_COL;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ball_x_q    <= xpos_t'(X_INIT);
            ball_y_q    <= ypos_t'(Y_INIT);
            dir_x_neg_q <= 1'b0;
            dir_y_neg_q <= 1'b0;
            timer_q     <= '0;
            plot_req_q  <= 1'b0;
            busy_q      <= 1'b0;
            colour_q    <= BG_COL;
        end else begin
            state_q     <= state_d;
            ball_x_q    <= ball_x_d;
            ball_y_q    <= ball_y_d;
            dir_x_neg_q <= dir_x_neg_d;
            dir_y_neg_q <= dir_y_neg_d;
            timer_q     <= timer_d;
            plot_req_q  <= plot_req_d;
            busy_q      <= busy_d;
            colour_q    <= colour_d;
        end
    end

    assign plot_if.plot_req   = plot_req_q;
    assign plot_if.plot       = scan_step;
    assign plot_if.x_out      = ball_x_q + {5'b00000, scan_col};
    assign plot_if.y_out      = ball_y_q + {4'b0000, scan_row};
    assign plot_if.colour_out = colour_q;

    assign frame_done = (state_q == ST_DRAW) && scan_step && scan_last;
    assign hit        = (state_q == ST_MOVE) && at_bottom && paddle_overlap;
    assign miss       = (state_q == ST_MOVE) && at_bottom && !paddle_overlap;
    assign busy       = busy_q;

endmodule

// File: tb/tb_ball_engine.sv
// Randomized bench for ball_engine: a frame-level model predicts every plotted pixel, the
// WAIT length, and the hit/miss outcome of each move; all observations go through check().
module tb_ball_engine;

    localparam int FT     = 4;
    localparam int BW     = 4;
    localparam int BH     = 4;
    localparam int XR     = 156;
    localparam int YB     = 116;
    localparam int X_INIT = 50;
    localparam int Y_INIT = 60;
    localparam int DX     = 1;
    localparam int DY     = 1;
    localparam int PW     = 16;

    typedef struct {
        int x;
        int y;
        int c;
        bit last;
    } pix_t;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       start    = 1'b0;
    logic       pause    = 1'b0;
    logic [7:0] paddle_x = 8'd0;
    logic       frame_done;
    logic       hit;
    logic       miss;
    logic       busy;

    ball_engine_if plot_if ();

    ball_engine #(
        .FRAME_TICKS (FT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pause      (pause),
        .paddle_x   (paddle_x),
        .plot_if    (plot_if),
        .frame_done (frame_done),
        .hit        (hit),
        .miss       (miss),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;

    // Frame-level model of the ball
    int   bx = X_INIT, by = Y_INIT, sx = 1, sy = 1;
    bit   m_idle = 1'b1;
    bit   in_wait = 1'b0;
    int   wait_cnt = 0;
    int   frames = 0;
    pix_t exp_q[$];
    pix_t cur;
    bit   cov_right = 0, cov_top = 0, cov_hit = 0, cov_miss = 0;

    task automatic check(input string tag, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    function automatic void push_sprite(input int x, input int y, input int c, input bit is_draw);
        for (int r = 0; r < BH; r++)
            for (int k = 0; k < BW; k++)
                exp_q.push_back('{x + k, y + r, c, is_draw && (r == BH - 1) && (k == BW - 1)});
    endfunction

    task automatic model_move(input int pad, output bit h, output bit m);
        int nx, ny, nsx, nsy;
        h = 0; m = 0; nsx = sx; nsy = sy;
        if (sx > 0) begin
            if (bx + DX >= XR) begin nx = XR; nsx = -1; cov_right = 1; end
            else nx = bx + DX;
        end else begin
            if (bx < DX) begin nx = 0; nsx = 1; end
            else nx = bx - DX;
        end
        if (sy > 0 && by + DY >= YB) begin
            if (bx <= pad + PW - 1 && pad <= bx + BW - 1) begin
                ny = YB; nsy = -1; h = 1; cov_hit = 1;
            end else begin
                m = 1; cov_miss = 1;
                nx = X_INIT; ny = Y_INIT; nsx = 1; nsy = 1;
            end
        end else if (sy > 0) begin
            ny = by + DY;
        end else if (by < DY) begin
            ny = 0; nsy = 1; cov_top = 1;
        end else begin
            ny = by - DY;
        end
        bx = nx; by = ny; sx = nsx; sy = nsy;
    endtask

    // Monitor: samples on the falling edge, between stimulus updates
    always @(negedge clk) begin
        bit eh, em, efd;
        eh = 0; em = 0; efd = 0;
        if (reset) begin
            exp_q.delete();
            bx = X_INIT; by = Y_INIT; sx = 1; sy = 1;
            m_idle = 1; in_wait = 0; wait_cnt = 0;
        end else begin
            check("plot_strobe", int'(plot_if.plot), int'(plot_if.plot_req & plot_if.plot_gnt));
            if (m_idle) begin
                check("idle_req", int'(plot_if.plot_req), 0);
                check("idle_busy", int'(busy), 0);
                check("idle_x", int'(plot_if.x_out), bx);
                check("idle_y", int'(plot_if.y_out), by);
                check("idle_colour", int'(plot_if.colour_out), 0);
                if (start) begin
                    push_sprite(bx, by, 7, 1);
                    m_idle = 0;
                end
            end else begin
                if (in_wait) begin
                    if (!busy) begin
                        check("wait_req", int'(plot_if.plot_req), 0);
                        if (!pause) wait_cnt++;
                    end else begin
                        check("wait_len", wait_cnt, FT);
                        in_wait = 0;
                    end
                end
                if (plot_if.plot_req) begin
                    check("scan_busy", int'(busy), 1);
                    if (exp_q.size() == 0) begin
                        check("pixels_pending", exp_q.size(), 1);
                    end else begin
                        cur = exp_q[0];
                        check("pix_x", int'(plot_if.x_out), cur.x);
                        check("pix_y", int'(plot_if.y_out), cur.y);
                        check("pix_colour", int'(plot_if.colour_out), cur.c);
                        if (plot_if.plot) begin
                            void'(exp_q.pop_front());
                            efd = cur.last;
                            if (cur.last) begin
                                frames++;
                                $display("frame %0d drawn at (%0d,%0d)", frames, bx, by);
                                push_sprite(bx, by, 0, 0);
                                in_wait = 1;
                                wait_cnt = 0;
                            end
                        end
                    end
                end else if (busy) begin
                    check("erase_complete", exp_q.size(), 0);
                    check("move_colour", int'(plot_if.colour_out), 0);
                    model_move(int'(paddle_x), eh, em);
                    push_sprite(bx, by, 7, 1);
                end
            end
            check("frame_done", int'(frame_done), int'(efd));
            check("hit", int'(hit), int'(eh));
            check("miss", int'(miss), int'(em));
        end
    end

    task automatic drive();
        int p;
        start = 1'($urandom_range(0, 1));
        if (frames % 7 == 2) plot_if.plot_gnt = ~plot_if.plot_gnt;
        else                 plot_if.plot_gnt = ($urandom_range(0, 3) != 0);
        if (frames % 5 == 1) pause = ($urandom_range(0, 9) != 0);
        else                 pause = ($urandom_range(0, 7) == 0);
        if (!busy) begin
            if (cov_miss) p = bx - int'($urandom_range(0, PW - 1)) + int'($urandom_range(0, BW - 1));
            else          p = bx + BW + int'($urandom_range(0, 60));
            if (p < 0)   p = 0;
            if (p > 255) p = 255;
            paddle_x = 8'(p);
        end
    endtask

    initial begin
        int cyc;
        int f0;
        plot_if.plot_gnt = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 start = 1'b1;

        cyc = 0;
        while (!(cov_right && cov_top && cov_hit && cov_miss) && cyc < 60000) begin
            @(posedge clk);
            #1;
            drive();
            cyc++;
        end
        check("bounces_covered", int'(cov_right && cov_top && cov_hit && cov_miss), 1);

        // Reset in the middle of a draw pass
        cyc = 0;
        while (!(plot_if.plot_req === 1'b1 && plot_if.colour_out === 3'b111) && cyc < 2000) begin
            @(posedge clk);
            #1;
            drive();
            cyc++;
        end
        check("draw_reached", int'(cyc < 2000), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        plot_if.plot_gnt = 1'b1;
        repeat (3) @(posedge clk);
        #1 start = 1'b1;

        f0 = frames;
        cyc = 0;
        while (frames < f0 + 2 && cyc < 2000) begin
            @(posedge clk);
            #1;
            drive();
            cyc++;
        end
        check("frames_after_reset", int'(frames >= f0 + 2), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
